regfile_read: RTL and testbench

//  Register-file end of the writeback interface: consumes rw/busW/regwr from the

---
 rtl/regfile_read.sv | 103 ++++++++++
 tb/tb_regfile_read.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_read.sv
// Register file at the writeback end of the pipeline.
// Two registered read ports with write-through bypass, r0 hardwired to zero,
// and a per-register pending scoreboard that stalls decode on RAW/WAW hazards
// against writes that are still in flight.
module regfile_read #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int NREGS = 2**AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          regwr,
  input  logic [AW-1:0] rw,
  input  logic [DW-1:0] busW,
  input  logic          rd_valid,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  input  logic          dst_wr,
  input  logic [AW-1:0] dst,
  output logic          stall,
  output logic [DW-1:0] busA,
  output logic [DW-1:0] busB,
  output logic          out_valid
);

  logic [DW-1:0]    regs [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_next;

  logic          clr_a;
  logic          clr_b;
  logic          clr_d;
  logic          pend_a;
  logic          pend_b;
  logic          pend_d;
  logic          acc;
  logic [DW-1:0] rdata_a;
  logic [DW-1:0] rdata_b;

  // Hazard detection: a writeback landing this cycle already releases its
  // register, so it neither stalls nor needs the stored value (bypass instead).
  always_comb begin
    clr_a   = regwr && (rw == ra)  && (ra  != '0);
    clr_b   = regwr && (rw == rb)  && (rb  != '0);
    clr_d   = regwr && (rw == dst) && (dst != '0);
    pend_a  = pending[ra]  && !clr_a;
    pend_b  = pending[rb]  && !clr_b;
    pend_d  = pending[dst] && !clr_d;
    stall   = rd_valid && (pend_a || pend_b || (dst_wr && pend_d));
    acc     = rd_valid && !stall;
    rdata_a = (ra == '0) ? '0 : (clr_a ? busW : regs[ra]);
    rdata_b = (rb == '0) ? '0 : (clr_b ? busW : regs[rb]);
  end

  // Scoreboard update: the writeback clear happens first, then a newly
  // accepted writer sets its bit, so a same-cycle clear and set leaves it set.
  always_comb begin
    pending_next = pending;
    if (regwr) begin
      pending_next[rw] = 1'b0;
    end
    if (acc && dst_wr && (dst != '0)) begin
      pending_next[dst] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  // Register storage; r0 is never written so it always reads back zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (regwr && (rw != '0)) begin
      regs[rw] <= busW;
    end
  end

  // Pending scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // Read port registers: capture on accept, otherwise hold the last data.
  always_ff @(posedge clk) begin
    if (reset) begin
      busA      <= '0;
      busB      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= acc;
      if (acc) begin
        busA <= rdata_a;
        busB <= rdata_b;
      end
    end
  end

endmodule

// File: tb/tb_regfile_read.sv
// Self-checking bench for regfile_read: directed scenarios plus a randomized
// run, all checked against a behavioural array/scoreboard model.
module tb_regfile_read;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NREGS = 32;

  logic          clk;
  logic          reset;
  logic          regwr;
  logic [AW-1:0] rw;
  logic [DW-1:0] busW;
  logic          rd_valid;
  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic          dst_wr;
  logic [AW-1:0] dst;
  logic          stall;
  logic [DW-1:0] busA;
  logic [DW-1:0] busB;
  logic          out_valid;

  int n_checks;
  int n_errors;

  // Reference model state
  logic [DW-1:0] m_regs [NREGS];
  bit            m_pend [NREGS];
  logic [DW-1:0] exp_a;
  logic [DW-1:0] exp_b;
  logic          exp_ov;

  regfile_read #(.DW(DW), .AW(AW), .NREGS(NREGS)) dut (
    .clk(clk),
    .reset(reset),
    .regwr(regwr),
    .rw(rw),
    .busW(busW),
    .rd_valid(rd_valid),
    .ra(ra),
    .rb(rb),
    .dst_wr(dst_wr),
    .dst(dst),
    .stall(stall),
    .busA(busA),
    .busB(busB),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A register counts as busy if the scoreboard holds it and no writeback
  // for it arrives in this very cycle.
  function automatic bit busy(input logic [AW-1:0] r);
    return m_pend[r] && !(regwr && rw == r && r != 0);
  endfunction

  function automatic bit model_stall();
    return rd_valid && (busy(ra) || busy(rb) || (dst_wr && busy(dst)));
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] r);
    if (r == 0) return '0;
    if (regwr && rw == r) return busW;
    return m_regs[r];
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit accept;
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
      exp_a  = '0;
      exp_b  = '0;
      exp_ov = 1'b0;
    end else begin
      accept = rd_valid && !model_stall();
      exp_ov = accept;
      if (accept) begin
        exp_a = model_read(ra);
        exp_b = model_read(rb);
      end
      if (regwr && rw != 0) m_regs[rw] = busW;
      if (regwr) m_pend[rw] = 1'b0;
      if (accept && dst_wr && dst != 0) m_pend[dst] = 1'b1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset    = 1'b0;
    regwr    = 1'b0;
    rw       = '0;
    busW     = '0;
    rd_valid = 1'b0;
    ra       = '0;
    rb       = '0;
    dst_wr   = 1'b0;
    dst      = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    regwr = 1'b1;
    rw    = 5'd1;
    busW  = 32'hCAFE_F00D;
    tick();
    n_checks++;
    if (busA !== 32'h0 || busB !== 32'h0 || out_valid !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL reset_outputs: got busA=%h busB=%h ov=%b, expected 0/0/0", busA, busB, out_valid);
    end
    idle();
    rd_valid = 1'b1;
    ra = 5'd1;
    rb = 5'd1;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL reset_no_stall: got %b expected 0", stall);
    end
    tick();
    n_checks++;
    if (busA !== 32'h0 || out_valid !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL reset_dropped_write: got busA=%h ov=%b, expected 0/1", busA, out_valid);
    end
  endtask

  task automatic test_write_read();
    idle();
    regwr = 1'b1;
    rw    = 5'd5;
    busW  = 32'h0000_DEAD;
    tick();
    idle();
    rd_valid = 1'b1;
    ra = 5'd5;
    tick();
    n_checks++;
    if (busA !== 32'h0000_DEAD || out_valid !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL write_read: got busA=%h ov=%b, expected 0000dead/1", busA, out_valid);
    end
    idle();
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || busA !== 32'h0000_DEAD) begin
      n_errors++;
      $display("[TB] FAIL hold_idle: got busA=%h ov=%b, expected 0000dead/0", busA, out_valid);
    end
  endtask

  task automatic test_r0();
    idle();
    regwr = 1'b1;
    rw    = 5'd0;
    busW  = 32'h1234;
    rd_valid = 1'b1;
    ra = 5'd0;
    rb = 5'd5;
    tick();
    n_checks++;
    if (busA !== 32'h0 || busB !== 32'h0000_DEAD) begin
      n_errors++;
      $display("[TB] FAIL r0_bypass: got busA=%h busB=%h, expected 0/0000dead", busA, busB);
    end
    idle();
    rd_valid = 1'b1;
    ra = 5'd0;
    rb = 5'd0;
    tick();
    n_checks++;
    if (busA !== 32'h0 || busB !== 32'h0) begin
      n_errors++;
      $display("[TB] FAIL r0_read: got busA=%h busB=%h, expected 0/0", busA, busB);
    end
  endtask

  task automatic test_bypass();
    idle();
    regwr = 1'b1;
    rw    = 5'd7;
    busW  = 32'h55;
    rd_valid = 1'b1;
    ra = 5'd7;
    rb = 5'd7;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL bypass_stall: got %b expected 0", stall);
    end
    tick();
    n_checks++;
    if (busA !== 32'h55 || busB !== 32'h55 || out_valid !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL bypass_data: got busA=%h busB=%h ov=%b, expected 55/55/1", busA, busB, out_valid);
    end
  endtask

  task automatic test_raw_stall();
    idle();
    rd_valid = 1'b1;
    dst_wr = 1'b1;
    dst = 5'd3;
    tick();
    idle();
    rd_valid = 1'b1;
    ra = 5'd3;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL raw_stall: got %b expected 1", stall);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL raw_wait_valid: got %b expected 0", out_valid);
    end
    regwr = 1'b1;
    rw = 5'd3;
    busW = 32'd9;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL raw_release: got %b expected 0", stall);
    end
    tick();
    n_checks++;
    if (busA !== 32'd9 || out_valid !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL raw_data: got busA=%h ov=%b, expected 9/1", busA, out_valid);
    end
  endtask

  task automatic test_set_wins();
    idle();
    rd_valid = 1'b1;
    dst_wr = 1'b1;
    dst = 5'd4;
    tick();
    regwr = 1'b1;
    rw = 5'd4;
    busW = 32'h44;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL waw_release: got %b expected 0", stall);
    end
    tick();
    idle();
    rd_valid = 1'b1;
    rb = 5'd4;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL set_wins: got %b expected 1", stall);
    end
    regwr = 1'b1;
    rw = 5'd4;
    busW = 32'h88;
    tick();
    n_checks++;
    if (busB !== 32'h88 || out_valid !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL set_wins_data: got busB=%h ov=%b, expected 88/1", busB, out_valid);
    end
  endtask

  task automatic test_reset_mid_stall();
    idle();
    rd_valid = 1'b1;
    ra = 5'd7;
    dst_wr = 1'b1;
    dst = 5'd2;
    tick();
    idle();
    rd_valid = 1'b1;
    ra = 5'd2;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL pre_reset_stall: got %b expected 1", stall);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (busA !== 32'h0 || busB !== 32'h0 || out_valid !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL mid_stall_reset: got busA=%h busB=%h ov=%b, expected 0/0/0", busA, busB, out_valid);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL post_reset_stall: got %b expected 0", stall);
    end
    tick();
    n_checks++;
    if (busA !== 32'h0 || out_valid !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL post_reset_read: got busA=%h ov=%b, expected 0/1", busA, out_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      regwr    = ($urandom_range(0, 1) == 1);
      rw       = AW'($urandom_range(0, 7));
      busW     = $urandom;
      rd_valid = ($urandom_range(0, 3) != 0);
      ra       = AW'($urandom_range(0, 7));
      rb       = ($urandom_range(0, 9) == 0) ? ra : AW'($urandom_range(0, 7));
      dst_wr   = ($urandom_range(0, 1) == 1);
      dst      = AW'($urandom_range(0, 7));
      #1;
      n_checks++;
      if (stall !== model_stall()) begin
        n_errors++;
        $display("[TB] FAIL rand_stall[%0d]: got %b expected %b", i, stall, model_stall());
      end
      tick();
      n_checks++;
      if (busA !== exp_a || busB !== exp_b || out_valid !== exp_ov) begin
        n_errors++;
        $display("[TB] FAIL rand_read[%0d]: got %h/%h/%b expected %h/%h/%b",
                 i, busA, busB, out_valid, exp_a, exp_b, exp_ov);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    exp_a  = '0;
    exp_b  = '0;
    exp_ov = 1'b0;
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_r0();
    test_bypass();
    test_raw_stall();
    test_set_wins();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
